// File: rtl/timer_pkg.sv
// Shared types for the bit timer: controller state encoding and a state decode helper.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SYNC = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } timer_state_t;

    // True for the states in which a packet is actively being timed.
    function automatic logic is_busy(input timer_state_t st);
        logic busy_v;
        busy_v = 1'b0;
        case (st)
            SYNC:    busy_v = 1'b1;
            RUN:     busy_v = 1'b1;
            default: busy_v = 1'b0;
        endcase
        return busy_v;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Modulo-rollover_val up-counter: counts 0 .. rollover_val-1 and wraps to 0.
// rollover_flag marks the last count of a period, so a caller can act on the
// edge that ends it. clear has priority over count_enable.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;
    logic [NUM_CNT_BITS-1:0] last_s;

    assign last_s        = rollover_val - CNT_ONE;
    assign count_out     = count_q;
    assign rollover_flag = (count_q == last_s);

    // Next count: clear, hold, increment, or wrap at the end of the period.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q >= last_s) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bit_timer_ctrl.sv
// Bit timer controller: after an accepted start it waits half a bit period,
// then emits one shift_strobe per bit period (mid-bit sample points) for N
// bits, pulses packet_done and returns to IDLE. All outputs are registered;
// strobes are therefore decided one cycle ahead from the clock counter.
module bit_timer_ctrl
    import timer_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_BIT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_CNT_BITS-1:0] clks_per_bit,
    input  logic [NUM_BIT_BITS-1:0] bits_per_pkt,
    output logic                    busy,
    output logic                    shift_strobe,
    output logic [NUM_BIT_BITS-1:0] bit_count,
    output logic                    packet_done
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_TWO = NUM_CNT_BITS'(2);
    localparam logic [NUM_BIT_BITS-1:0] BIT_ONE = NUM_BIT_BITS'(1);

    timer_state_t            state_q, state_d;
    logic [NUM_CNT_BITS-1:0] c_q, c_d;
    logic [NUM_BIT_BITS-1:0] n_q, n_d;
    logic [NUM_BIT_BITS-1:0] bit_count_q, bit_count_d;
    logic                    busy_q, busy_d;
    logic                    strobe_q, strobe_d;
    logic                    done_q, done_d;

    logic                    start_acc_s;
    logic                    cnt_clear_s;
    logic                    clk_en_s;
    logic [NUM_CNT_BITS-1:0] half_s;
    logic [NUM_CNT_BITS-1:0] clk_roll_s;
    logic [NUM_CNT_BITS-1:0] clk_cnt_s;
    logic                    clk_flag_s;
    logic [NUM_BIT_BITS-1:0] bit_cnt_s;
    logic                    bit_flag_s;

    // Abort wins over start; start is only honoured in IDLE.
    assign start_acc_s = (state_q == IDLE) && start && !abort;
    assign cnt_clear_s = start_acc_s || abort || (state_q == DONE);
    assign clk_en_s    = is_busy(state_q);
    assign half_s      = c_q >> 1;
    assign clk_roll_s  = (state_q == SYNC) ? half_s : c_q;

    // Clock counter: half-period in SYNC, full bit period in RUN.
    flex_counter #(.NUM_CNT_BITS(NUM_CNT_BITS)) u_clk_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear_s),
        .count_enable  (clk_en_s),
        .rollover_val  (clk_roll_s),
        .count_out     (clk_cnt_s),
        .rollover_flag (clk_flag_s)
    );

    // Bit counter: advances on each strobe; its flag marks the Nth strobe.
    flex_counter #(.NUM_CNT_BITS(NUM_BIT_BITS)) u_bit_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear_s),
        .count_enable  (strobe_q),
        .rollover_val  (n_q),
        .count_out     (bit_cnt_s),
        .rollover_flag (bit_flag_s)
    );

    // Next state, latched packet parameters and registered-output lookahead.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        n_d     = n_q;
        if (strobe_q) begin
            bit_count_d = bit_cnt_s + BIT_ONE;
        end else begin
            bit_count_d = bit_count_q;
        end
        case (state_q)
            IDLE: begin
                if (start_acc_s) begin
                    state_d     = SYNC;
                    c_d         = (clks_per_bit < CNT_TWO) ? CNT_TWO : clks_per_bit;
                    n_d         = (bits_per_pkt == '0) ? BIT_ONE : bits_per_pkt;
                    bit_count_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SYNC: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (clk_flag_s) begin
                    state_d = RUN;
                end else begin
                    state_d = SYNC;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (strobe_q && bit_flag_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d   = is_busy(state_d);
        done_d   = (state_d == DONE);
        // The strobe lands in the cycle where the counter shows C-1.
        strobe_d = (state_q == RUN) && (state_d == RUN) && (clk_cnt_s == (c_q - CNT_TWO));
    end

    // Controller state and outputs, cleared asynchronously by n_rst.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            c_q         <= '0;
            n_q         <= '0;
            bit_count_q <= '0;
            busy_q      <= 1'b0;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            n_q         <= n_d;
            bit_count_q <= bit_count_d;
            busy_q      <= busy_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
        end
    end

    assign busy         = busy_q;
    assign shift_strobe = strobe_q;
    assign bit_count    = bit_count_q;
    assign packet_done  = done_q;

endmodule

// File: tb/tb_bit_timer_ctrl.sv
// Scoreboard bench for bit_timer_ctrl: a packet-level reference model pushes
// the expected per-cycle outputs; a monitor on the falling edge compares.
module tb_bit_timer_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] clks_per_bit = 4'd0;
    logic [3:0] bits_per_pkt = 4'd0;
    logic       busy;
    logic       shift_strobe;
    logic [3:0] bit_count;
    logic       packet_done;

    always #5 clk = ~clk;

    bit_timer_ctrl #(.NUM_CNT_BITS(4), .NUM_BIT_BITS(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .abort        (abort),
        .clks_per_bit (clks_per_bit),
        .bits_per_pkt (bits_per_pkt),
        .busy         (busy),
        .shift_strobe (shift_strobe),
        .bit_count    (bit_count),
        .packet_done  (packet_done)
    );

    typedef struct packed {
        logic       busy;
        logic       strobe;
        logic       done;
        logic [3:0] bc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: one packet described by its start cycle and C, N, H.
    bit m_active  = 1'b0;
    int m_s       = 0;
    int m_c       = 2;
    int m_n       = 1;
    int m_h       = 1;
    int m_last_bc = 0;
    int cyc       = 0;

    // Strobes issued at relative cycles 1..x of the current packet.
    function automatic int strobes_upto(input int x);
        int k;
        if (x < m_h + m_c) k = 0;
        else k = (x - m_h) / m_c;
        if (k > m_n) k = m_n;
        return k;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   r;
        int   total;
        e = '0;
        if (!m_active) begin
            e.bc = 4'(m_last_bc);
        end else begin
            r        = cyc - m_s;
            total    = m_h + m_c * m_n;
            e.busy   = (r >= 1) && (r <= total);
            e.strobe = (r > m_h) && (r <= total) && (((r - m_h) % m_c) == 0);
            e.done   = (r == total + 1);
            e.bc     = 4'(strobes_upto(r - 1));
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One clock cycle: push the expected outputs, then apply the inputs.
    task automatic step(input bit st, input bit ab, input logic [3:0] c, input logic [3:0] n);
        @(posedge clk);
        #1;
        cyc++;
        if (m_active && (cyc - m_s > m_h + m_c * m_n + 1)) begin
            m_active  = 1'b0;
            m_last_bc = m_n;
        end
        exp_q.push_back(model_out());
        start        = st;
        abort        = ab;
        clks_per_bit = c;
        bits_per_pkt = n;
        if (ab) begin
            if (m_active) begin
                m_last_bc = strobes_upto(cyc - m_s);
                m_active  = 1'b0;
            end
        end else if (st && !m_active) begin
            m_active = 1'b1;
            m_s      = cyc;
            m_c      = (int'(c) < 2) ? 2 : int'(c);
            m_n      = (n == 4'd0) ? 1 : int'(n);
            m_h      = m_c / 2;
        end
    endtask

    // Asynchronous reset in mid-cycle, checked immediately, then released.
    task automatic do_reset();
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_async_outputs", 32'({busy, shift_strobe, packet_done, bit_count}), 32'd0);
        m_active  = 1'b0;
        m_last_bc = 0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if ({busy, shift_strobe, packet_done, bit_count} !== mon_e) begin
                n_fail++;
                $display("FAIL sb t=%0t got busy=%0b strobe=%0b done=%0b bc=%0d expected busy=%0b strobe=%0b done=%0b bc=%0d",
                         $time, busy, shift_strobe, packet_done, bit_count,
                         mon_e.busy, mon_e.strobe, mon_e.done, mon_e.bc);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'({busy, shift_strobe, packet_done, bit_count}), 32'd0);
        n_rst = 1'b1;

        // Nominal packet C=4 N=3; parameter inputs wander after latching.
        step(1'b1, 1'b0, 4'd4, 4'd3);
        repeat (18) step(1'b0, 1'b0, 4'($urandom()), 4'($urandom()));

        // Clamping: C=0 -> 2, N=0 -> 1.
        step(1'b1, 1'b0, 4'd0, 4'd0);
        repeat (6) step(1'b0, 1'b0, 4'd0, 4'd0);

        // Abort in relative cycle 9 of a C=4 N=3 packet.
        step(1'b1, 1'b0, 4'd4, 4'd3);
        repeat (8) step(1'b0, 1'b0, 4'd4, 4'd3);
        step(1'b0, 1'b1, 4'd4, 4'd3);
        repeat (6) step(1'b0, 1'b0, 4'd4, 4'd3);

        // Start held high, clks_per_bit changing mid-packet.
        step(1'b1, 1'b0, 4'd4, 4'd3);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 4'($urandom()), 4'd3);
        step(1'b0, 1'b1, 4'd0, 4'd0);
        repeat (3) step(1'b0, 1'b0, 4'd4, 4'd3);

        // Start and abort together in IDLE.
        step(1'b1, 1'b1, 4'd4, 4'd3);
        repeat (8) step(1'b0, 1'b0, 4'd4, 4'd3);

        // Reset pulled mid-RUN after the first strobe.
        step(1'b1, 1'b0, 4'd4, 4'd3);
        repeat (7) step(1'b0, 1'b0, 4'd4, 4'd3);
        do_reset();
        repeat (20) step(1'b0, 1'b0, 4'd4, 4'd3);

        // Randomised traffic with occasional aborts and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else begin
                step($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                     4'($urandom()), 4'($urandom()));
            end
        end
        repeat (2) step(1'b0, 1'b0, 4'd4, 4'd3);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_timer_ctrl.md
BIT_TIMER_CTRL -- requirements
Module: bit_timer_ctrl

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 4: width of the clocks-per-bit field and the clock counter.
REQ-002 SHALL have parameter NUM_BIT_BITS, default 4: width of the bits-per-packet field and the bit counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin one packet; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate the packet immediately; valid in every state.
REQ-007 SHALL have port clks_per_bit  input  NUM_CNT_BITS  bit period C, in clk cycles.
REQ-008 SHALL have port bits_per_pkt  input  NUM_BIT_BITS  packet length N, in bits.
REQ-009 SHALL have port busy  output  1  high in SYNC and RUN.
REQ-010 SHALL have port shift_strobe  output  1  one-cycle pulse at each mid-bit sample point.
REQ-011 SHALL have port bit_count  output  NUM_BIT_BITS  strobes issued so far in the current packet.
REQ-012 SHALL have port packet_done  output  1  one-cycle pulse after the Nth strobe.

Function
REQ-013 SHALL implement the states IDLE, SYNC, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1 and abort=0, latch C and N, clear both counters and bit_count, and enter SYNC on the next edge.
REQ-015 SHALL clamp the latched C to 2 when clks_per_bit<2, and the latched N to 1 when bits_per_pkt=0.
REQ-016 SHALL ignore clks_per_bit and bits_per_pkt changes after latching, until the next accepted start.
REQ-017 SHALL remain in SYNC for exactly H=floor(C/2) cycles, then enter RUN.
REQ-018 SHALL, in RUN, assert shift_strobe once every C cycles; the first strobe occurs exactly H+C cycles after the cycle in which start was sampled.
REQ-019 SHALL increment bit_count in the cycle after each strobe, wrapping modulo 2^NUM_BIT_BITS.
REQ-020 SHALL enter DONE from RUN on the edge ending the Nth strobe cycle.
REQ-021 SHALL assert packet_done for exactly the one DONE cycle, with busy=0, then return to IDLE.
REQ-022 SHALL ignore start in SYNC, RUN and DONE; there is no queuing.
REQ-023 SHALL, on abort=1 in any state, enter IDLE on the next edge, clear the counters, suppress any strobe due in that cycle and never assert packet_done.
REQ-024 SHALL give abort priority when start and abort are both 1 in IDLE: the block stays in IDLE.
REQ-025 SHALL hold bit_count at its final value in IDLE until the next accepted start.

Reset
REQ-026 SHALL, while n_rst=0, force state=IDLE, busy=0, shift_strobe=0, packet_done=0, bit_count=0, and clear the latched C, N and all counters, independently of clk.
REQ-027 SHALL, when reset asserts mid-packet, emit no strobe and no packet_done afterwards; the block then waits for a new start.

Structure
REQ-028 SHALL take the state enum typedef (IDLE, SYNC, RUN, DONE) from shared package timer_pkg.
REQ-029 SHALL instantiate the existing flex_counter twice:
- clock counter, NUM_CNT_BITS wide, rollover_val = H in SYNC and C in RUN;
- bit counter, NUM_BIT_BITS wide, count_enable = shift_strobe, rollover_val = N.
REQ-030 SHALL drive the clear input of both counter instances from an accepted start, from abort and from DONE.

Verification
REQ-031 SHALL be verified with C=4, N=3, start pulsed in cycle 0 -> busy=1 in cycles 1-14; strobes in cycles 6, 10, 14; packet_done in cycle 15; IDLE in cycle 16; bit_count=3.
REQ-032 SHALL be verified with clks_per_bit=0 and bits_per_pkt=0, start in cycle 0 -> clamped C=2, N=1; one strobe in cycle 3; packet_done in cycle 4.
REQ-033 SHALL be verified with C=4, N=3, abort in cycle 9 -> IDLE in cycle 10; no strobe in cycle 10; no packet_done; bit_count=1.
REQ-034 SHALL be verified with start held high through a packet and clks_per_bit changed mid-packet -> strobe timing unchanged; a new packet starts only from IDLE, in cycle 16 when start is still high.
REQ-035 SHALL be verified with n_rst pulled low asynchronously mid-RUN -> all outputs 0 immediately; no strobe or packet_done after release until a new start.
REQ-036 SHALL be verified with start=1 and abort=1 in the same IDLE cycle -> busy stays 0; no strobes.
